// File: rtl/div_mon_pkg.sv
// Shared definitions for the div2 period monitor: FSM state encoding, fault codes
// and the nominal divided period for the div2 ratio.
package div_mon_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISMATCH = 2'b01,
        FC_STALL    = 2'b10
    } fault_code_t;

    // div2 toggles every 8 ip1 cycles, so one full divided period is 16 ip1 cycles.
    localparam int DIV2_EXP_PERIOD = 16;

endpackage

// File: rtl/sync_rise_det.sv
// Brings the divided clock into the ip1 domain through two flops and flags each
// rising edge with a single-cycle combinational pulse.
module sync_rise_det (
    input  logic ip1,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 only delays s2 for edge detection; it is never used as a data sample.
    assign rise = s2 & ~s3;

endmodule

// File: rtl/div_period_monitor.sv
// Watches the div2 output from the fast ip1 domain: ticks on each rising edge,
// measures the divided period, declares lock and latches stall/mismatch faults.
module div_period_monitor
    import div_mon_pkg::*;
#(
    parameter int PERIOD_W   = 8,
    parameter int EXP_PERIOD = DIV2_EXP_PERIOD,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic                ip1,
    input  logic                reset,
    input  logic                div_in,
    input  logic                clear_fault,
    output logic                tick,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic [CNT_W-1:0]    edge_count
);

    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_W-1:0] EXP_P     = PERIOD_W'(EXP_PERIOD);
    localparam logic [PERIOD_W-1:0] TOL_P     = PERIOD_W'(TOL);
    localparam logic [PERIOD_W-1:0] TIMEOUT_P = PERIOD_W'(TIMEOUT);
    localparam logic [3:0]          LOCK_P    = 4'(LOCK_COUNT);

    mon_state_t          state;
    logic [3:0]          match_cnt;
    logic [PERIOD_W-1:0] cyc_cnt;
    logic [PERIOD_W-1:0] meas_period;
    logic [PERIOD_W-1:0] period_diff;
    logic                rise;
    logic                match;
    logic                timeout_hit;
    logic                measuring;

    sync_rise_det u_sync (
        .ip1   (ip1),
        .reset (reset),
        .din   (div_in),
        .rise  (rise)
    );

    // The counter holds "cycles since last rise minus one", so the period is one more.
    assign meas_period = (cyc_cnt == CNT_MAX) ? CNT_MAX : cyc_cnt + PERIOD_W'(1);
    assign period_diff = (meas_period >= EXP_P) ? (meas_period - EXP_P) : (EXP_P - meas_period);
    assign match       = (period_diff <= TOL_P);
    assign timeout_hit = (cyc_cnt >= TIMEOUT_P) && !rise;
    assign measuring   = (state == MEAS) || (state == LOCKED);

    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if (rise || clear_fault) begin
            cyc_cnt <= '0;
        end else if (cyc_cnt != CNT_MAX) begin
            cyc_cnt <= cyc_cnt + PERIOD_W'(1);
        end
    end

    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            tick       <= 1'b0;
            edge_count <= '0;
        end else begin
            tick <= rise;
            if (rise && (state != FAULT)) begin
                edge_count <= edge_count + CNT_W'(1);
            end
        end
    end

    // A clear restarts acquisition outright, so a coincident rise is neither
    // reported as a period nor taken as the new reference edge.
    always_ff @(posedge ip1 or posedge reset) begin
        if (reset) begin
            state        <= ACQ;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= FC_NONE;
        end else begin
            period_valid <= 1'b0;
            if (rise && measuring && !clear_fault) begin
                period       <= meas_period;
                period_valid <= 1'b1;
            end

            if (clear_fault) begin
                state      <= ACQ;
                match_cnt  <= '0;
                locked     <= 1'b0;
                fault      <= 1'b0;
                fault_code <= FC_NONE;
            end else begin
                case (state)
                    ACQ: begin
                        if (rise) begin
                            state     <= MEAS;
                            match_cnt <= '0;
                        end else if (timeout_hit) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= FC_STALL;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            if (match) begin
                                match_cnt <= match_cnt + 4'd1;
                                if ((match_cnt + 4'd1) == LOCK_P) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end else if (timeout_hit) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= FC_STALL;
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            if (!match) begin
                                state      <= FAULT;
                                locked     <= 1'b0;
                                fault      <= 1'b1;
                                fault_code <= FC_MISMATCH;
                            end
                        end else if (timeout_hit) begin
                            state      <= FAULT;
                            locked     <= 1'b0;
                            fault      <= 1'b1;
                            fault_code <= FC_STALL;
                        end
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                    default: begin
                        state     <= ACQ;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                        fault     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_period_monitor.sv
// Directed bench for div_period_monitor: expected responses per rising edge are queued
// as stimulus is issued and a monitor compares them whenever the DUT ticks.
`timescale 1ns/1ps
module tb_div_period_monitor;

    typedef struct {
        logic        pv;
        logic [7:0]  per;
        logic        lk;
        logic        flt;
        logic [1:0]  code;
        logic [15:0] edges;
    } exp_t;

    logic        ip1;
    logic        reset;
    logic        div_in;
    logic        clear_fault;
    logic        tick;
    logic [7:0]  period;
    logic        period_valid;
    logic        locked;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] edge_count;

    exp_t exp_q[$];
    int   total;
    int   bad;

    // TOL=1 so that periods 15/17 match while 18 and 12 do not.
    div_period_monitor #(
        .PERIOD_W   (8),
        .EXP_PERIOD (16),
        .TOL        (1),
        .LOCK_COUNT (4),
        .TIMEOUT    (64),
        .CNT_W      (16)
    ) dut (
        .ip1          (ip1),
        .reset        (reset),
        .div_in       (div_in),
        .clear_fault  (clear_fault),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault),
        .fault_code   (fault_code),
        .edge_count   (edge_count)
    );

    initial ip1 = 1'b0;
    always #5 ip1 = ~ip1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int n);
        div_in = 1'b0;
        repeat (n) @(posedge ip1);
        #1;
    endtask

    // One divided period starting with a rise: hi cycles high, lo cycles low.
    // The queued record is what the DUT must show on the tick of this rise.
    task automatic applyStimulus(input int hi, input int lo, input bit clr,
                                 input logic pv, input logic [7:0] per, input logic lk,
                                 input logic flt, input logic [1:0] code, input logic [15:0] edges);
        exp_t e;
        e.pv = pv; e.per = per; e.lk = lk; e.flt = flt; e.code = code; e.edges = edges;
        exp_q.push_back(e);
        div_in = 1'b1;
        for (int i = 0; i < hi; i++) begin
            clear_fault = clr && (i == 2);
            @(posedge ip1);
            #1;
        end
        clear_fault = 1'b0;
        div_in = 1'b0;
        repeat (lo) @(posedge ip1);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tick"}, 32'(tick), 0);
        checkOutput({tag, "_period"}, 32'(period), 0);
        checkOutput({tag, "_pv"}, 32'(period_valid), 0);
        checkOutput({tag, "_locked"}, 32'(locked), 0);
        checkOutput({tag, "_fault"}, 32'(fault), 0);
        checkOutput({tag, "_code"}, 32'(fault_code), 0);
        checkOutput({tag, "_edges"}, 32'(edge_count), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge ip1);
            if (!reset) begin
                if (tick) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL tick_unexpected: got tick=1, want no tick (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("pv", 32'(period_valid), 32'(e.pv));
                        checkOutput("period", 32'(period), 32'(e.per));
                        checkOutput("locked", 32'(locked), 32'(e.lk));
                        checkOutput("fault", 32'(fault), 32'(e.flt));
                        checkOutput("fault_code", 32'(fault_code), 32'(e.code));
                        checkOutput("edge_count", 32'(edge_count), 32'(e.edges));
                    end
                end else begin
                    checkOutput("pv_without_tick", 32'(period_valid), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1;
        div_in = 1'b0;
        clear_fault = 1'b0;
        repeat (3) @(posedge ip1);
        #1;
        checkAllZero("reset");
        reset = 1'b0;
        idle(4);

        // Acquire: reference edge, tolerance hits (17, 15), a miss (18) that restarts counting.
        applyStimulus(8, 8,  0, 0, 8'd0,  0, 0, 2'd0, 16'd1);
        applyStimulus(8, 8,  0, 1, 8'd16, 0, 0, 2'd0, 16'd2);
        applyStimulus(8, 9,  0, 1, 8'd16, 0, 0, 2'd0, 16'd3);
        applyStimulus(8, 10, 0, 1, 8'd17, 0, 0, 2'd0, 16'd4);
        applyStimulus(8, 8,  0, 1, 8'd18, 0, 0, 2'd0, 16'd5);
        applyStimulus(8, 8,  0, 1, 8'd16, 0, 0, 2'd0, 16'd6);
        applyStimulus(8, 7,  0, 1, 8'd16, 0, 0, 2'd0, 16'd7);
        applyStimulus(8, 8,  0, 1, 8'd15, 0, 0, 2'd0, 16'd8);
        applyStimulus(8, 8,  0, 1, 8'd16, 1, 0, 2'd0, 16'd9);
        applyStimulus(8, 9,  0, 1, 8'd16, 1, 0, 2'd0, 16'd10);
        applyStimulus(8, 8,  0, 1, 8'd17, 1, 0, 2'd0, 16'd11);

        // Stall while locked.
        idle(30);
        checkOutput("stall_not_yet", 32'(fault), 0);
        idle(40);
        checkOutput("stall_fault", 32'(fault), 1);
        checkOutput("stall_code", 32'(fault_code), 2);
        checkOutput("stall_locked", 32'(locked), 0);
        checkOutput("stall_edges", 32'(edge_count), 11);

        // Rise while faulted: tick only, everything else frozen.
        applyStimulus(8, 8,  0, 0, 8'd17, 0, 1, 2'd2, 16'd11);

        clear_fault = 1'b1;
        @(posedge ip1);
        #1;
        clear_fault = 1'b0;
        checkOutput("clear_fault", 32'(fault), 0);
        checkOutput("clear_code", 32'(fault_code), 0);
        checkOutput("clear_locked", 32'(locked), 0);

        // Relock, then a 12-cycle period while locked.
        applyStimulus(8, 8,  0, 0, 8'd17, 0, 0, 2'd0, 16'd12);
        applyStimulus(8, 8,  0, 1, 8'd16, 0, 0, 2'd0, 16'd13);
        applyStimulus(8, 8,  0, 1, 8'd16, 0, 0, 2'd0, 16'd14);
        applyStimulus(8, 8,  0, 1, 8'd16, 0, 0, 2'd0, 16'd15);
        applyStimulus(6, 6,  0, 1, 8'd16, 1, 0, 2'd0, 16'd16);
        applyStimulus(8, 8,  0, 1, 8'd12, 0, 1, 2'd1, 16'd17);
        applyStimulus(8, 8,  0, 0, 8'd12, 0, 1, 2'd1, 16'd17);

        // Clear coincident with a rise: that rise is not the reference, the next one is.
        applyStimulus(8, 8,  1, 0, 8'd12, 0, 0, 2'd0, 16'd17);
        applyStimulus(8, 8,  0, 0, 8'd12, 0, 0, 2'd0, 16'd18);
        applyStimulus(8, 8,  0, 1, 8'd16, 0, 0, 2'd0, 16'd19);

        // Asynchronous reset between clock edges while measuring.
        @(posedge ip1);
        #3;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        repeat (2) @(posedge ip1);
        #1;
        reset = 1'b0;
        idle(4);
        applyStimulus(8, 8,  0, 0, 8'd0,  0, 0, 2'd0, 16'd1);
        applyStimulus(8, 8,  0, 1, 8'd16, 0, 0, 2'd0, 16'd2);
        idle(6);

        checkOutput("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
